// File: rtl/fcl_pixel_streamer.sv
// Buffers one frame of pool/flatten pixels, clears the FC layer, then replays the frame one pixel per cycle.
// Define FCL_STREAMER_ZERO_PAD_EN to let Input_Finish close a short frame, which is then padded with zeros.
module fcl_pixel_streamer #(
    parameter int NUM_PIXELS  = 16,
    parameter int PIXEL_WIDTH = 16,
    parameter int CNT_WIDTH   = 5
) (
    input  logic                   Clock,
    input  logic                   Input_Reset,
    input  logic [PIXEL_WIDTH-1:0] Input_Pixel,
    input  logic                   Input_Valid,
    input  logic                   Input_Finish,
    output logic                   Input_Ready,
    output logic [PIXEL_WIDTH-1:0] Output_Pixel,
    output logic                   Output_Valid,
    output logic                   Output_Finish,
    output logic                   Output_Reset,
    input  logic                   Downstream_Done,
    output logic [15:0]            Frame_Count
);

    localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_PIXELS - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(NUM_PIXELS);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_CLR    = 2'd1,
        S_STREAM = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   wptr_q, wptr_d;
    logic [CNT_WIDTH-1:0]   rptr_q, rptr_d;
    logic [PIXEL_WIDTH-1:0] out_pixel_q, out_pixel_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_finish_q, out_finish_d;
    logic                   out_reset_q, out_reset_d;
    logic [15:0]            frame_count_q, frame_count_d;

    logic [PIXEL_WIDTH-1:0] buf_q [NUM_PIXELS];
    logic                   accept;
    logic                   wr_en;
    logic [PIXEL_WIDTH-1:0] rd_data;

`ifdef FCL_STREAMER_ZERO_PAD_EN
    logic [CNT_WIDTH-1:0]   fill_len_q, fill_len_d;
`else
    logic                   unused_finish;
    assign unused_finish = Input_Finish;
`endif

    assign Input_Ready   = (state_q == S_FILL);
    assign accept        = Input_Valid && Input_Ready;
    assign Output_Pixel  = out_pixel_q;
    assign Output_Valid  = out_valid_q;
    assign Output_Finish = out_finish_q;
    assign Output_Reset  = out_reset_q;
    assign Frame_Count   = frame_count_q;

    // Entries past the end of a short frame read as zero instead of being cleared.
    always_comb begin
        rd_data = buf_q[rptr_q[IDX_W-1:0]];
`ifdef FCL_STREAMER_ZERO_PAD_EN
        if (rptr_q >= fill_len_q) begin
            rd_data = '0;
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        out_pixel_d   = out_pixel_q;
        out_valid_d   = 1'b0;
        out_finish_d  = 1'b0;
        out_reset_d   = 1'b0;
        frame_count_d = frame_count_q;
        wr_en         = 1'b0;
`ifdef FCL_STREAMER_ZERO_PAD_EN
        fill_len_d    = fill_len_q;
`endif

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    if (wptr_q == LAST_IDX) begin
                        state_d = S_CLR;
                    end
                end
`ifdef FCL_STREAMER_ZERO_PAD_EN
                fill_len_d = accept ? (wptr_q + 1'b1) : wptr_q;
                if (Input_Finish && (accept || (wptr_q != '0))) begin
                    state_d = S_CLR;
                end
`endif
                if (state_d == S_CLR) begin
                    out_reset_d = 1'b1;
                    rptr_d      = '0;
                end
            end

            S_CLR: begin
                state_d     = S_STREAM;
                out_pixel_d = rd_data;
                out_valid_d = 1'b1;
                rptr_d      = rptr_q + 1'b1;
            end

            // Each output register is loaded one edge ahead, so the STREAM cycle count equals NUM_PIXELS.
            S_STREAM: begin
                if (rptr_q == FULL_CNT) begin
                    state_d      = S_WAIT;
                    out_finish_d = 1'b1;
                end else begin
                    out_pixel_d = rd_data;
                    out_valid_d = 1'b1;
                    rptr_d      = rptr_q + 1'b1;
                end
            end

            S_WAIT: begin
                if (Downstream_Done) begin
                    frame_count_d = frame_count_q + 16'd1;
                    wptr_d        = '0;
                    state_d       = S_FILL;
                end else begin
                    out_finish_d = 1'b1;
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Input_Reset) begin
            state_q       <= S_FILL;
            wptr_q        <= '0;
            rptr_q        <= '0;
            out_pixel_q   <= '0;
            out_valid_q   <= 1'b0;
            out_finish_q  <= 1'b0;
            out_reset_q   <= 1'b0;
            frame_count_q <= '0;
`ifdef FCL_STREAMER_ZERO_PAD_EN
            fill_len_q    <= FULL_CNT;
`endif
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            out_pixel_q   <= out_pixel_d;
            out_valid_q   <= out_valid_d;
            out_finish_q  <= out_finish_d;
            out_reset_q   <= out_reset_d;
            frame_count_q <= frame_count_d;
`ifdef FCL_STREAMER_ZERO_PAD_EN
            fill_len_q    <= fill_len_d;
`endif
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            buf_q[wptr_q[IDX_W-1:0]] <= Input_Pixel;
        end
    end

endmodule
